// File: rtl/huffman_ctrl.sv
// Huffman code builder: five merges of the two smallest active slots, which yield per-symbol code words and masks.
// Latency is 36 cycles from the CNT_valid capture to the code_valid pulse; CNT_valid is ignored unless the block is idle.
module huffman_ctrl #(
  parameter int NSYM = 6,
  parameter int CW   = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       CNT_valid,
  input  logic [7:0] CNT1,
  input  logic [7:0] CNT2,
  input  logic [7:0] CNT3,
  input  logic [7:0] CNT4,
  input  logic [7:0] CNT5,
  input  logic [7:0] CNT6,
  output logic       busy,
  output logic       code_valid,
  output logic [7:0] HC1,
  output logic [7:0] HC2,
  output logic [7:0] HC3,
  output logic [7:0] HC4,
  output logic [7:0] HC5,
  output logic [7:0] HC6,
  output logic [7:0] M1,
  output logic [7:0] M2,
  output logic [7:0] M3,
  output logic [7:0] M4,
  output logic [7:0] M5,
  output logic [7:0] M6
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] MERGE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [2:0] LAST_IDX   = 3'(NSYM - 1);
  localparam logic [2:0] LAST_ROUND = 3'(NSYM - 2);

  logic [1:0]      state;
  logic [2:0]      idx;
  logic [2:0]      round;

  logic [CW-1:0]   slot_cnt  [NSYM];
  logic [NSYM-1:0] slot_mask [NSYM];
  logic [NSYM-1:0] slot_act;

  logic [2:0]      min1_idx;
  logic [2:0]      min2_idx;
  logic            min1_vld;
  logic            min2_vld;

  logic [7:0]      hc [NSYM];
  logic [7:0]      m  [NSYM];
  logic [7:0]      cnt_in [NSYM];

  logic [CW-1:0]   scan_cnt;
  logic            lt_min1;
  logic            lt_min2;
  logic [CW-1:0]   merge_sum;
  logic [NSYM-1:0] merge_mask;
  logic [2:0]      merge_lo;
  logic [2:0]      merge_hi;

  assign cnt_in[0] = CNT1;
  assign cnt_in[1] = CNT2;
  assign cnt_in[2] = CNT3;
  assign cnt_in[3] = CNT4;
  assign cnt_in[4] = CNT5;
  assign cnt_in[5] = CNT6;

  // Strict less-than plus ascending scan order keeps the lower slot on ties.
  assign scan_cnt = slot_cnt[idx];
  assign lt_min1  = !min1_vld || (scan_cnt < slot_cnt[min1_idx]);
  assign lt_min2  = !min2_vld || (scan_cnt < slot_cnt[min2_idx]);

  assign merge_sum  = slot_cnt[min1_idx] + slot_cnt[min2_idx];
  assign merge_mask = slot_mask[min1_idx] | slot_mask[min2_idx];
  assign merge_lo   = (min1_idx < min2_idx) ? min1_idx : min2_idx;
  assign merge_hi   = (min1_idx < min2_idx) ? min2_idx : min1_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      code_valid <= 1'b0;
      idx        <= 3'd0;
      round      <= 3'd0;
      for (int i = 0; i < NSYM; i++) begin
        hc[i] <= 8'd0;
        m[i]  <= 8'd0;
      end
    end else begin
      code_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (CNT_valid) begin
            state <= SCAN;
            busy  <= 1'b1;
            idx   <= 3'd0;
            round <= 3'd0;
            for (int i = 0; i < NSYM; i++) begin
              hc[i] <= 8'd0;
              m[i]  <= 8'd0;
            end
          end
        end
        SCAN: begin
          if (idx == LAST_IDX) begin
            idx   <= 3'd0;
            state <= MERGE;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        MERGE: begin
          // The min1 subtree gets a leading 1, the min2 subtree a leading 0.
          for (int i = 0; i < NSYM; i++) begin
            if (slot_mask[min1_idx][i]) begin
              hc[i] <= hc[i] | (m[i] + 8'd1);
              m[i]  <= {m[i][6:0], 1'b1};
            end else if (slot_mask[min2_idx][i]) begin
              m[i] <= {m[i][6:0], 1'b1};
            end
          end
          round <= round + 3'd1;
          if (round == LAST_ROUND) begin
            state      <= DONE;
            busy       <= 1'b0;
            code_valid <= 1'b1;
          end else begin
            state <= SCAN;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Slot and minimum tracking need no reset: every capture reloads them.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (CNT_valid) begin
          for (int k = 0; k < NSYM; k++) begin
            slot_cnt[k]  <= CW'(cnt_in[k]);
            slot_mask[k] <= NSYM'(1) << k;
          end
          slot_act <= '1;
          min1_vld <= 1'b0;
          min2_vld <= 1'b0;
        end
      end
      SCAN: begin
        if (slot_act[idx]) begin
          if (lt_min1) begin
            min2_idx <= min1_idx;
            min2_vld <= min1_vld;
            min1_idx <= idx;
            min1_vld <= 1'b1;
          end else if (lt_min2) begin
            min2_idx <= idx;
            min2_vld <= 1'b1;
          end
        end
      end
      MERGE: begin
        slot_cnt[merge_lo]  <= merge_sum;
        slot_mask[merge_lo] <= merge_mask;
        slot_act[merge_hi]  <= 1'b0;
        min1_vld            <= 1'b0;
        min2_vld            <= 1'b0;
      end
      default: ;
    endcase
  end

  assign HC1 = hc[0];
  assign HC2 = hc[1];
  assign HC3 = hc[2];
  assign HC4 = hc[3];
  assign HC5 = hc[4];
  assign HC6 = hc[5];
  assign M1  = m[0];
  assign M2  = m[1];
  assign M3  = m[2];
  assign M4  = m[3];
  assign M5  = m[4];
  assign M6  = m[5];

endmodule
